// File: rtl/led_pkg.sv
// Shared constants and types for the PWM LED fader.
package led_pkg;

   localparam int unsigned NUM_CH_DEF    = 4;
   localparam int unsigned PWM_BITS_DEF  = 8;
   localparam int unsigned STEP_DIV_DEF  = 50000;
   localparam int unsigned DUTY_STEP_DEF = 1;

   typedef enum logic [1:0] {
      IDLE_OFF  = 2'd0,
      RAMP_UP   = 2'd1,
      IDLE_ON   = 2'd2,
      RAMP_DOWN = 2'd3
   } ramp_state_e;

   // Full-scale duty for a given PWM counter width.
   function automatic int unsigned dmax_of(input int unsigned bits);
      return (32'd1 << bits) - 32'd1;
   endfunction

endpackage

// File: rtl/led_fade_chan.sv
// One LED channel: input register, duty ramp toward the requested level,
// and PWM compare against the shared counter.
module led_fade_chan
   import led_pkg::*;
#(
   parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
   parameter int unsigned DUTY_STEP = DUTY_STEP_DEF
) (
   input  logic                FAB_CLK,
   input  logic                FAB_RESET,
   input  logic                led_in,
   input  logic                fade_en,
   input  logic                step_tick,
   input  logic [PWM_BITS-1:0] pwm_cnt,
   output logic                led_out,
   output logic                busy_c
);

   localparam int unsigned         W1   = PWM_BITS + 1;
   localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(dmax_of(PWM_BITS));
   localparam logic [W1-1:0]       STEP = W1'(DUTY_STEP);

   logic                in_q;
   logic [PWM_BITS-1:0] duty;
   logic [PWM_BITS-1:0] target_c;
   logic [PWM_BITS-1:0] duty_nxt_c;
   logic [W1-1:0]       up_c;
   logic [W1-1:0]       dn_c;
   ramp_state_e         state_c;

   assign target_c = in_q ? DMAX : '0;
   assign busy_c   = (duty != target_c);

   // State register: duty is the ramp state, in_q and led_out ride along.
   always_ff @(posedge FAB_CLK) begin
      if (FAB_RESET) begin
         in_q    <= 1'b0;
         duty    <= '0;
         led_out <= 1'b0;
      end else begin
         in_q    <= led_in;
         duty    <= duty_nxt_c;
         led_out <= (pwm_cnt < duty);
      end
   end

   // Ramp state decoded from duty versus target.
   always_comb begin
      state_c = IDLE_OFF;
      if (duty < target_c) begin
         state_c = RAMP_UP;
      end else if (duty > target_c) begin
         state_c = RAMP_DOWN;
      end else if (duty == DMAX) begin
         state_c = IDLE_ON;
      end
   end

   // Next duty: snap when fading is off, otherwise saturating step on tick.
   always_comb begin
      up_c       = {1'b0, duty} + STEP;
      dn_c       = {1'b0, duty} - STEP;
      duty_nxt_c = duty;
      if (!fade_en) begin
         duty_nxt_c = target_c;
      end else if (step_tick) begin
         case (state_c)
            RAMP_UP:
               duty_nxt_c = (up_c >= {1'b0, target_c}) ? target_c : up_c[PWM_BITS-1:0];
            RAMP_DOWN:
               duty_nxt_c = (dn_c[PWM_BITS] || (dn_c[PWM_BITS-1:0] <= target_c))
                            ? target_c : dn_c[PWM_BITS-1:0];
            default:
               duty_nxt_c = duty;
         endcase
      end
   end

endmodule

// File: rtl/led_fade_pwm.sv
// PWM LED driver with per-channel brightness fading; shared PWM and step
// timebases keep all channels phase-aligned.
module led_fade_pwm
   import led_pkg::*;
#(
   parameter int unsigned NUM_CH    = NUM_CH_DEF,
   parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
   parameter int unsigned STEP_DIV  = STEP_DIV_DEF,
   parameter int unsigned DUTY_STEP = DUTY_STEP_DEF
) (
   input  logic              FAB_CLK,
   input  logic              FAB_RESET,
   input  logic [NUM_CH-1:0] LED_IN,
   input  logic              FADE_EN,
   output logic [NUM_CH-1:0] LED_OUT,
   output logic              BUSY
);

   localparam int unsigned DMAX = dmax_of(PWM_BITS);
   localparam int unsigned SW   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   logic [PWM_BITS-1:0] pwm_cnt;
   logic [SW-1:0]       step_cnt;
   logic                step_tick_c;
   logic [NUM_CH-1:0]   busy_c;

   assign step_tick_c = (step_cnt == SW'(STEP_DIV - 1));

   // PWM period is DMAX cycles so duty=DMAX stays solidly on.
   always_ff @(posedge FAB_CLK) begin
      if (FAB_RESET) begin
         pwm_cnt  <= '0;
         step_cnt <= '0;
         BUSY     <= 1'b0;
      end else begin
         pwm_cnt  <= (pwm_cnt == PWM_BITS'(DMAX - 1)) ? '0 : pwm_cnt + PWM_BITS'(1);
         step_cnt <= step_tick_c ? '0 : step_cnt + SW'(1);
         BUSY     <= |busy_c;
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      led_fade_chan #(
         .PWM_BITS  (PWM_BITS),
         .DUTY_STEP (DUTY_STEP)
      ) u_chan (
         .FAB_CLK   (FAB_CLK),
         .FAB_RESET (FAB_RESET),
         .led_in    (LED_IN[i]),
         .fade_en   (FADE_EN),
         .step_tick (step_tick_c),
         .pwm_cnt   (pwm_cnt),
         .led_out   (LED_OUT[i]),
         .busy_c    (busy_c[i])
      );
   end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm: three instances (step 1 / step 4 / slow step 3).
module tb_led_fade_pwm;

   logic       FAB_CLK = 1'b0;
   logic       FAB_RESET;
   logic [3:0] LED_IN;
   logic       FADE_EN;
   logic [3:0] a_out, b_out, c_out;
   logic       a_busy, b_busy, c_busy;
   int         checks   = 0;
   int         failures = 0;

   always #5 FAB_CLK = ~FAB_CLK;

   led_fade_pwm #(.NUM_CH(4), .PWM_BITS(4), .STEP_DIV(4), .DUTY_STEP(1)) u_a (
      .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .LED_IN(LED_IN), .FADE_EN(FADE_EN),
      .LED_OUT(a_out), .BUSY(a_busy));
   led_fade_pwm #(.NUM_CH(4), .PWM_BITS(4), .STEP_DIV(4), .DUTY_STEP(4)) u_b (
      .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .LED_IN(LED_IN), .FADE_EN(FADE_EN),
      .LED_OUT(b_out), .BUSY(b_busy));
   led_fade_pwm #(.NUM_CH(4), .PWM_BITS(4), .STEP_DIV(40), .DUTY_STEP(3)) u_c (
      .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .LED_IN(LED_IN), .FADE_EN(FADE_EN),
      .LED_OUT(c_out), .BUSY(c_busy));

   wire [3:0] a_d1 = u_a.g_ch[1].u_chan.duty;
   wire [3:0] a_d2 = u_a.g_ch[2].u_chan.duty;
   wire [3:0] b_d0 = u_b.g_ch[0].u_chan.duty;
   wire [3:0] c_d0 = u_c.g_ch[0].u_chan.duty;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] pick(input int sel);
      case (sel)
         1:       return a_d1;
         2:       return a_d2;
         3:       return b_d0;
         default: return c_d0;
      endcase
   endfunction

   function automatic logic out_bit(input int inst, input int ch);
      case (inst)
         0:       return a_out[ch[1:0]];
         1:       return b_out[ch[1:0]];
         default: return c_out[ch[1:0]];
      endcase
   endfunction

   task automatic wait_change(input int sel, input logic [3:0] prev,
                              output logic [3:0] now, output int cyc);
      cyc = 0;
      now = prev;
      while (now === prev && cyc < 300) begin
         @(negedge FAB_CLK);
         cyc++;
         now = pick(sel);
      end
      if (now === prev) check_eq("wait_timeout", cyc, 0);
   endtask

   task automatic count_high(input int inst, input int ch, input int n, output int hi);
      hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge FAB_CLK);
         hi += int'(out_bit(inst, ch));
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge FAB_CLK);
      FAB_RESET = 1'b1;
      repeat (n) @(negedge FAB_CLK);
      FAB_RESET = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] now;
      int         cyc;
      int         hi;
      int         e;

      // 1: reset holds outputs low, then solid on two edges after in_q captures.
      FAB_RESET = 1'b1;
      LED_IN    = 4'hF;
      FADE_EN   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge FAB_CLK);
         check_eq("t1_rst_out", a_out, 0);
         check_eq("t1_rst_busy", a_busy, 0);
      end
      FAB_RESET = 1'b0;
      @(negedge FAB_CLK);
      check_eq("t1_r1_out", a_out, 0);
      @(negedge FAB_CLK);
      check_eq("t1_r2_out", a_out, 0);
      @(negedge FAB_CLK);
      check_eq("t1_r3_out", a_out, 4'hF);
      hi = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge FAB_CLK);
         if (a_out == 4'hF) hi++;
      end
      check_eq("t1_solid", hi, 15);

      // 2: FADE_EN=0 snaps duty, BUSY pulses one cycle.
      LED_IN = 4'h0;
      do_reset(1);
      repeat (4) @(negedge FAB_CLK);
      LED_IN = 4'b0001;
      @(negedge FAB_CLK);
      check_eq("t2_busy_e1", a_busy, 0);
      @(negedge FAB_CLK);
      check_eq("t2_duty_e2", u_a.g_ch[0].u_chan.duty, 15);
      check_eq("t2_out_e2", a_out[0], 0);
      check_eq("t2_busy_e2", a_busy, 1);
      @(negedge FAB_CLK);
      check_eq("t2_out_e3", a_out[0], 1);
      check_eq("t2_busy_e3", a_busy, 0);
      count_high(0, 0, 15, hi);
      check_eq("t2_on_cnt", hi, 15);
      LED_IN = 4'b0000;
      repeat (2) @(negedge FAB_CLK);
      check_eq("t2_duty_off", u_a.g_ch[0].u_chan.duty, 0);
      @(negedge FAB_CLK);
      check_eq("t2_off_busy", a_busy, 0);
      count_high(0, 0, 15, hi);
      check_eq("t2_off_cnt", hi, 0);

      // 3: ramp up by one per tick, four cycles apart, BUSY until full.
      FADE_EN = 1'b1;
      do_reset(1);
      repeat (2) @(negedge FAB_CLK);
      LED_IN = 4'b0010;
      now = 4'd0;
      for (int k = 1; k <= 15; k++) begin
         wait_change(1, now, now, cyc);
         check_eq("t3_duty", now, k);
         check_eq("t3_busy", a_busy, 1);
         if (k > 1) check_eq("t3_interval", cyc, 4);
      end
      @(negedge FAB_CLK);
      check_eq("t3_busy_done", a_busy, 0);
      count_high(0, 1, 15, hi);
      check_eq("t3_full_cnt", hi, 15);

      // 4: reversal at duty 7 walks back down without jumping.
      LED_IN = 4'b0100;
      do_reset(1);
      now = 4'd0;
      for (int k = 1; k <= 7; k++) begin
         wait_change(2, now, now, cyc);
         check_eq("t4_up", now, k);
      end
      LED_IN = 4'b0000;
      for (int k = 6; k >= 0; k--) begin
         wait_change(2, now, now, cyc);
         check_eq("t4_down", now, k);
         check_eq("t4_interval", cyc, 4);
      end
      repeat (20) @(negedge FAB_CLK);
      check_eq("t4_rest", a_d2, 0);
      check_eq("t4_busy", a_busy, 0);

      // 5: DUTY_STEP=4 saturates at both ends.
      LED_IN = 4'b0001;
      do_reset(1);
      now = 4'd0;
      for (int k = 1; k <= 4; k++) begin
         e = (4 * k > 15) ? 15 : 4 * k;
         wait_change(3, now, now, cyc);
         check_eq("t5_up", now, e);
      end
      LED_IN = 4'b0000;
      for (int k = 1; k <= 4; k++) begin
         e = (4 * k > 15) ? 0 : 15 - 4 * k;
         wait_change(3, now, now, cyc);
         check_eq("t5_down", now, e);
      end

      // 6: one-cycle reset at duty 9 aborts the ramp; then FADE_EN=0 snaps.
      LED_IN = 4'b0010;
      do_reset(1);
      now = 4'd0;
      for (int k = 1; k <= 9; k++) begin
         wait_change(1, now, now, cyc);
         check_eq("t6_up", now, k);
      end
      FAB_RESET = 1'b1;
      @(negedge FAB_CLK);
      check_eq("t6_rst_duty", a_d1, 0);
      check_eq("t6_rst_out", a_out, 0);
      check_eq("t6_rst_busy", a_busy, 0);
      FAB_RESET = 1'b0;
      wait_change(1, 4'd0, now, cyc);
      check_eq("t6_restart", now, 1);
      check_eq("t6_restart_cyc", cyc, 4);
      FADE_EN = 1'b0;
      @(negedge FAB_CLK);
      check_eq("t6_snap", a_d1, 15);

      // 7: PWM high count per period matches a held duty.
      FADE_EN = 1'b1;
      LED_IN  = 4'b0001;
      do_reset(1);
      now = 4'd0;
      for (int k = 1; k <= 5; k++) begin
         e = (3 * k > 15) ? 15 : 3 * k;
         wait_change(4, now, now, cyc);
         check_eq("t7_duty", now, e);
         count_high(2, 0, 15, hi);
         check_eq("t7_high_cnt", hi, e);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
